// File: rtl/l2_controller_if.sv
// L1/L2/memory handshake bundle for the L2 tag/state controller.
// The controller side uses the slave modport.
interface l2_controller_if #(
    parameter int unsigned TAG_W   = 50,
    parameter int unsigned INDEX_W = 8
);
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               read_L1_L2;
    logic               write_L1_L2;
    logic               flush;
    logic               ready;
    logic               refill;
    logic               update;
    logic               way;
    logic               read_L2_MEM;
    logic               write_L2_MEM;
    logic [TAG_W-1:0]   mem_tag;
    logic [INDEX_W-1:0] mem_index;
    logic               ready_MEM;
    logic               flush_done;

    modport slave (
        input  tag, index, read_L1_L2, write_L1_L2, flush, ready_MEM,
        output ready, refill, update, way, read_L2_MEM, write_L2_MEM,
               mem_tag, mem_index, flush_done
    );

    modport master (
        output tag, index, read_L1_L2, write_L1_L2, flush, ready_MEM,
        input  ready, refill, update, way, read_L2_MEM, write_L2_MEM,
               mem_tag, mem_index, flush_done
    );
endinterface

// File: rtl/l2_controller.sv
// L2 tag/state controller: 2-way set-associative, write-back, write-allocate,
// 1-bit LRU per set, with a full flush sweep. All outputs are registered.
module l2_controller #(
    parameter int unsigned TAG_W   = 50,
    parameter int unsigned INDEX_W = 8
) (
    input logic            clk,
    input logic            nrst,
    l2_controller_if.slave bus
);
    localparam int unsigned SETS  = 2 ** INDEX_W;
    localparam int unsigned CNT_W = INDEX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_REFILL, S_FLUSH, S_DONE
    } state_t;

    state_t             r_state;
    logic               r_req_wr;
    logic [TAG_W-1:0]   r_req_tag;
    logic [INDEX_W-1:0] r_req_idx;
    logic               r_hit;
    logic               r_hit_way;
    logic               r_victim;
    logic               r_victim_dirty;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0][SETS-1:0] r_valid;
    logic [1:0][SETS-1:0] r_dirty;
    logic [SETS-1:0]      r_lru;
    logic [TAG_W-1:0]     r_tags [2][SETS];

    logic               r_ready, r_refill, r_update, r_way;
    logic               r_rd_mem, r_wr_mem, r_flush_done;
    logic [TAG_W-1:0]   r_mem_tag;
    logic [INDEX_W-1:0] r_mem_index;

    // Lookup of the incoming request, evaluated in IDLE and latched for COMPARE
    logic w_m0, w_m1, w_hit, w_hit_way, w_lk_victim, w_lk_vdirty, w_req, w_req_wr;
    assign w_m0        = r_valid[0][bus.index] && (r_tags[0][bus.index] == bus.tag);
    assign w_m1        = r_valid[1][bus.index] && (r_tags[1][bus.index] == bus.tag);
    assign w_hit       = w_m0 | w_m1;
    assign w_hit_way   = ~w_m0;
    assign w_lk_victim = !r_valid[0][bus.index] ? 1'b0 :
                         (!r_valid[1][bus.index] ? 1'b1 : r_lru[bus.index]);
    assign w_lk_vdirty = r_valid[w_lk_victim][bus.index] && r_dirty[w_lk_victim][bus.index];
    assign w_req       = bus.read_L1_L2 | bus.write_L1_L2;
    assign w_req_wr    = !bus.read_L1_L2 && bus.write_L1_L2;

    logic               w_fl_way, w_fl_dirty, w_fl_last, w_fl_adv, w_install;
    logic [INDEX_W-1:0] w_fl_set;
    logic [TAG_W-1:0]   w_victim_tag;
    assign w_fl_way     = r_cnt[0];
    assign w_fl_set     = r_cnt[CNT_W-1:1];
    assign w_fl_dirty   = r_valid[w_fl_way][w_fl_set] && r_dirty[w_fl_way][w_fl_set];
    assign w_fl_last    = &r_cnt;
    assign w_fl_adv     = r_wr_mem ? bus.ready_MEM : !w_fl_dirty;
    assign w_victim_tag = r_tags[r_victim][r_req_idx];
    assign w_install    = ((r_state == S_COMPARE) && !r_hit && !r_victim_dirty && r_req_wr)
                       || (r_state == S_REFILL);

    always_ff @(posedge clk) begin
        if (w_install) r_tags[r_victim][r_req_idx] <= r_req_tag;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_req_wr       <= 1'b0;
            r_req_tag      <= '0;
            r_req_idx      <= '0;
            r_hit          <= 1'b0;
            r_hit_way      <= 1'b0;
            r_victim       <= 1'b0;
            r_victim_dirty <= 1'b0;
            r_cnt          <= '0;
            r_valid        <= '0;
            r_dirty        <= '0;
            r_lru          <= '0;
            r_ready        <= 1'b0;
            r_refill       <= 1'b0;
            r_update       <= 1'b0;
            r_way          <= 1'b0;
            r_rd_mem       <= 1'b0;
            r_wr_mem       <= 1'b0;
            r_flush_done   <= 1'b0;
            r_mem_tag      <= '0;
            r_mem_index    <= '0;
        end else begin
            r_ready      <= 1'b0;
            r_refill     <= 1'b0;
            r_update     <= 1'b0;
            r_flush_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.flush) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                    end else if (w_req) begin
                        r_state        <= S_COMPARE;
                        r_req_wr       <= w_req_wr;
                        r_req_tag      <= bus.tag;
                        r_req_idx      <= bus.index;
                        r_hit          <= w_hit;
                        r_hit_way      <= w_hit_way;
                        r_victim       <= w_lk_victim;
                        r_victim_dirty <= w_lk_vdirty;
                        r_way          <= w_hit ? w_hit_way : w_lk_victim;
                        // Outcomes that complete in COMPARE raise ready on entry
                        if (w_hit || (w_req_wr && !w_lk_vdirty)) begin
                            r_ready  <= 1'b1;
                            r_update <= w_req_wr;
                        end
                    end
                end
                S_COMPARE: begin
                    if (r_hit) begin
                        r_lru[r_req_idx] <= ~r_hit_way;
                        if (r_req_wr) r_dirty[r_hit_way][r_req_idx] <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_victim_dirty) begin
                        r_state     <= S_WRITE_BACK;
                        r_wr_mem    <= 1'b1;
                        r_mem_tag   <= w_victim_tag;
                        r_mem_index <= r_req_idx;
                    end else if (!r_req_wr) begin
                        r_state     <= S_ALLOCATE;
                        r_rd_mem    <= 1'b1;
                        r_mem_tag   <= r_req_tag;
                        r_mem_index <= r_req_idx;
                    end else begin
                        r_valid[r_victim][r_req_idx] <= 1'b1;
                        r_dirty[r_victim][r_req_idx] <= 1'b1;
                        r_lru[r_req_idx]             <= ~r_victim;
                        r_state                      <= S_IDLE;
                    end
                end
                S_WRITE_BACK: begin
                    if (bus.ready_MEM) begin
                        r_wr_mem                     <= 1'b0;
                        r_dirty[r_victim][r_req_idx] <= 1'b0;
                        r_victim_dirty               <= 1'b0;
                        r_state                      <= S_COMPARE;
                        if (r_req_wr) begin
                            r_ready  <= 1'b1;
                            r_update <= 1'b1;
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (bus.ready_MEM) begin
                        r_rd_mem <= 1'b0;
                        r_refill <= 1'b1;
                        r_state  <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    r_valid[r_victim][r_req_idx] <= 1'b1;
                    r_dirty[r_victim][r_req_idx] <= 1'b0;
                    r_lru[r_req_idx]             <= ~r_victim;
                    r_hit                        <= 1'b1;
                    r_hit_way                    <= r_victim;
                    r_ready                      <= 1'b1;
                    r_state                      <= S_COMPARE;
                end
                S_FLUSH: begin
                    // Dirty entry: raise the write first, retire it once memory acknowledges
                    if (w_fl_adv) begin
                        r_wr_mem                   <= 1'b0;
                        r_valid[w_fl_way][w_fl_set] <= 1'b0;
                        r_dirty[w_fl_way][w_fl_set] <= 1'b0;
                        r_cnt                      <= r_cnt + CNT_W'(1);
                        if (w_fl_last) begin
                            r_state      <= S_DONE;
                            r_flush_done <= 1'b1;
                        end
                    end else if (!r_wr_mem) begin
                        r_wr_mem    <= 1'b1;
                        r_way       <= w_fl_way;
                        r_mem_tag   <= r_tags[w_fl_way][w_fl_set];
                        r_mem_index <= w_fl_set;
                    end
                end
                S_DONE: begin
                    r_lru   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready        = r_ready;
    assign bus.refill       = r_refill;
    assign bus.update       = r_update;
    assign bus.way          = r_way;
    assign bus.read_L2_MEM  = r_rd_mem;
    assign bus.write_L2_MEM = r_wr_mem;
    assign bus.mem_tag      = r_mem_tag;
    assign bus.mem_index    = r_mem_index;
    assign bus.flush_done   = r_flush_done;
endmodule

// File: tb/tb_l2_controller.sv
// Self-checking bench for l2_controller: directed vector table, flush/reset
// sequences and random traffic against a behavioural cache model.
module tb_l2_controller;
    localparam int TW   = 8;
    localparam int IW   = 2;
    localparam int SETS = 4;

    typedef struct packed {
        logic          wr;
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
    } mem_op_t;

    typedef struct {
        int rdy; int way; int upd; int nref; int nfetch;
        int nwb; int wb_tag; int fetch_tag; int bad_idx;
    } res_t;

    typedef struct {
        bit wr; int tag; int idx;
        int rdy; int way; int upd; int nref; int nwb; int wb_tag;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;

    l2_controller_if #(.TAG_W(TW), .INDEX_W(IW)) bus ();
    l2_controller #(.TAG_W(TW), .INDEX_W(IW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      mem_lat  = 1;
    mem_op_t q_mem[$];
    mem_op_t exp_fl[$];

    int m_valid [2][SETS];
    int m_dirty [2][SETS];
    int m_tag   [2][SETS];
    int m_lru   [SETS];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Memory: acknowledge each request in its mem_lat-th high cycle, log the transfer
    initial begin
        int cnt;
        cnt = 0;
        bus.ready_MEM = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!nrst) begin
                cnt = 0;
                bus.ready_MEM = 1'b0;
            end else if ((bus.read_L2_MEM || bus.write_L2_MEM) && !bus.ready_MEM) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.ready_MEM = 1'b1;
                    q_mem.push_back('{wr: bus.write_L2_MEM, tag: bus.mem_tag, idx: bus.mem_index});
                    cnt = 0;
                end
            end else begin
                bus.ready_MEM = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 0; m_dirty[w][s] = 0; m_tag[w][s] = 0;
            end
        for (int s = 0; s < SETS; s++) m_lru[s] = 0;
    endtask

    // Expected outcome of one request, and the cache state after it
    task automatic model_access(input bit wr, input int t, input int ix, input int lat, output res_t e);
        int hw, v, dv;
        e = '{default: 0};
        e.fetch_tag = t;
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_valid[w][ix] != 0 && m_tag[w][ix] == t) hw = w;
        if (hw >= 0) begin
            e.rdy = 1; e.way = hw; e.upd = int'(wr);
            m_lru[ix] = 1 - hw;
            if (wr) m_dirty[hw][ix] = 1;
        end else begin
            v  = (m_valid[0][ix] == 0) ? 0 : ((m_valid[1][ix] == 0) ? 1 : m_lru[ix]);
            dv = (m_valid[v][ix] != 0 && m_dirty[v][ix] != 0) ? 1 : 0;
            e.way = v; e.nwb = dv; e.wb_tag = m_tag[v][ix];
            if (wr) begin
                e.rdy = 1 + dv * (lat + 1); e.upd = 1;
            end else begin
                e.rdy = dv * (lat + 1) + lat + 3; e.nref = 1; e.nfetch = 1;
            end
            m_tag[v][ix] = t; m_valid[v][ix] = 1; m_dirty[v][ix] = int'(wr);
            m_lru[ix] = 1 - v;
        end
    endtask

    task automatic compare_res(input string nm, input res_t o, input res_t e);
        check({nm, " ready_cycle"}, o.rdy, e.rdy);
        check({nm, " way"}, o.way, e.way);
        check({nm, " update"}, o.upd, e.upd);
        check({nm, " refill_pulses"}, o.nref, e.nref);
        check({nm, " mem_reads"}, o.nfetch, e.nfetch);
        check({nm, " mem_writes"}, o.nwb, e.nwb);
        check({nm, " mem_index"}, o.bad_idx, 0);
        if (e.nwb > 0) check({nm, " wb_tag"}, o.wb_tag, e.wb_tag);
        if (e.nfetch > 0) check({nm, " fetch_tag"}, o.fetch_tag, e.fetch_tag);
    endtask

    // Drive one request from the IDLE cycle; returns one cycle into the following IDLE
    task automatic do_txn(input bit wr, input int t, input int ix, output res_t o);
        q_mem.delete();
        o = '{default: 0};
        o.rdy = -1;
        bus.read_L1_L2  = !wr;
        bus.write_L1_L2 = wr;
        bus.tag         = TW'(t);
        bus.index       = IW'(ix);
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (bus.refill) o.nref++;
            if (bus.ready) begin
                o.rdy = c; o.way = int'(bus.way); o.upd = int'(bus.update);
                break;
            end
        end
        bus.read_L1_L2  = 1'b0;
        bus.write_L1_L2 = 1'b0;
        foreach (q_mem[i]) begin
            if (int'(q_mem[i].idx) != ix) o.bad_idx++;
            if (q_mem[i].wr) begin o.nwb++; o.wb_tag = int'(q_mem[i].tag); end
            else begin o.nfetch++; o.fetch_tag = int'(q_mem[i].tag); end
        end
        @(posedge clk); #1;
    endtask

    // Flush sweep, optionally with a read raised in the same IDLE cycle
    task automatic run_flush(input bit with_read, input int t, input int ix);
        int   exp_done, done, early, nd;
        res_t o, e;
        exp_fl.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[w][s] != 0 && m_dirty[w][s] != 0)
                    exp_fl.push_back('{wr: 1'b1, tag: TW'(m_tag[w][s]), idx: IW'(s)});
        nd = exp_fl.size();
        exp_done = 2 * SETS + nd * mem_lat + 1;
        model_reset();
        q_mem.delete();
        bus.flush = 1'b1;
        if (with_read) begin
            bus.read_L1_L2 = 1'b1; bus.tag = TW'(t); bus.index = IW'(ix);
        end
        done = -1; early = 0;
        for (int c = 1; c <= 500; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.flush = 1'b0;
            if (bus.ready) early++;
            if (bus.flush_done) begin done = c; break; end
        end
        check("flush_done cycle", done, exp_done);
        check("ready during flush", early, 0);
        check("flush write count", q_mem.size(), nd);
        for (int i = 0; i < nd && i < q_mem.size(); i++)
            check("flush write op", longint'(q_mem[i]), longint'(exp_fl[i]));
        if (with_read) begin
            model_access(1'b0, t, ix, mem_lat, e);
            e.rdy = e.rdy + 1;
            do_txn(1'b0, t, ix, o);
            compare_res("read after flush", o, e);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[9];

    initial begin
        res_t o, e;
        bit   wr;
        int   t, ix;

        tbl[0] = '{1'b0, 5, 3, 4, 0, 0, 1, 0, 0};
        tbl[1] = '{1'b0, 5, 3, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 9, 3, 1, 1, 1, 0, 0, 0};
        tbl[3] = '{1'b0, 5, 3, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{1'b0, 7, 3, 6, 1, 0, 1, 1, 9};
        tbl[5] = '{1'b1, 7, 3, 1, 1, 1, 0, 0, 0};
        tbl[6] = '{1'b1, 2, 1, 1, 0, 1, 0, 0, 0};
        tbl[7] = '{1'b0, 5, 3, 1, 0, 0, 0, 0, 0};
        tbl[8] = '{1'b0, 8, 3, 6, 1, 0, 1, 1, 7};

        nrst = 1'b0;
        bus.tag = '0; bus.index = '0;
        bus.read_L1_L2 = 1'b0; bus.write_L1_L2 = 1'b0; bus.flush = 1'b0;
        @(posedge clk); #1;
        check("reset outputs", longint'({bus.ready, bus.refill, bus.update, bus.way,
              bus.read_L2_MEM, bus.write_L2_MEM, bus.mem_tag, bus.mem_index, bus.flush_done}), 0);
        nrst = 1'b1;
        model_reset();
        @(posedge clk); #1;

        mem_lat = 1;
        for (int i = 0; i < 9; i++) begin
            e = '{default: 0};
            e.rdy = tbl[i].rdy; e.way = tbl[i].way; e.upd = tbl[i].upd;
            e.nref = tbl[i].nref; e.nfetch = tbl[i].nref; e.nwb = tbl[i].nwb;
            e.wb_tag = tbl[i].wb_tag; e.fetch_tag = tbl[i].tag;
            model_access(tbl[i].wr, tbl[i].tag, tbl[i].idx, mem_lat, o);
            do_txn(tbl[i].wr, tbl[i].tag, tbl[i].idx, o);
            compare_res($sformatf("vec%0d", i), o, e);
        end

        // Reset while a refill is outstanding
        mem_lat = 6;
        bus.read_L1_L2 = 1'b1; bus.tag = TW'(6); bus.index = IW'(0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.read_L2_MEM) break;
        end
        check("allocate reached", int'(bus.read_L2_MEM), 1);
        nrst = 1'b0;
        #1;
        check("outputs after mid reset", longint'({bus.ready, bus.refill, bus.update, bus.way,
              bus.read_L2_MEM, bus.write_L2_MEM, bus.mem_tag, bus.mem_index, bus.flush_done}), 0);
        bus.read_L1_L2 = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        mem_lat = 1;
        model_access(1'b0, 5, 3, mem_lat, e);
        do_txn(1'b0, 5, 3, o);
        compare_res("post-reset read", o, e);

        // One dirty line at set 2 way 1, then flush
        model_access(1'b0, 1, 2, mem_lat, e);
        do_txn(1'b0, 1, 2, o);
        compare_res("flush prep rd", o, e);
        model_access(1'b1, 3, 2, mem_lat, e);
        do_txn(1'b1, 3, 2, o);
        compare_res("flush prep wr", o, e);
        run_flush(1'b0, 0, 0);
        model_access(1'b0, 5, 3, mem_lat, e);
        do_txn(1'b0, 5, 3, o);
        compare_res("read after flush miss", o, e);

        run_flush(1'b1, 5, 3);

        for (int n = 0; n < 150; n++) begin
            mem_lat = int'($urandom_range(1, 3));
            t  = int'($urandom_range(0, 3));
            ix = int'($urandom_range(0, SETS - 1));
            if ($urandom_range(0, 19) == 0) begin
                run_flush(1'($urandom_range(0, 1)), t, ix);
            end else begin
                wr = 1'($urandom_range(0, 1));
                model_access(wr, t, ix, mem_lat, e);
                do_txn(wr, t, ix, o);
                compare_res($sformatf("rand%0d", n), o, e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/l2_controller.md
# L2_controller

Tag/state controller for the unified L2 cache, directly downstream of `L1_D_controller`. It serves L1 line reads (refills) and L1 dirty-line write-backs over the `read_L1_L2` / `write_L1_L2` / `ready` handshake. It keeps the L2 array as a 2-way set-associative, write-back, write-allocate store with 1-bit LRU per set. It drives the L2 data array and the main-memory handshake, and supports a full flush sweep.

## Interface
- `TAG_W`, default 50: tag width; 64 − 6 offset − `INDEX_W`.
- `INDEX_W`, default 8: set index width; 2^`INDEX_W` sets, 64-byte lines, same line size as L1.
- `clk` input, 1: clock; all state changes on the rising edge.
- `nrst` input, 1: asynchronous active-low reset.
- `tag` input, `TAG_W`: request tag; held stable by L1 until `ready`.
- `index` input, `INDEX_W`: request set; held stable until `ready`.
- `read_L1_L2` input, 1: L1 line-read request (L1 miss refill).
- `write_L1_L2` input, 1: L1 full-line write-back request.
- `flush` input, 1: start a flush sweep; sampled only in IDLE.
- `ready` output, 1: one-cycle pulse; request completed.
- `refill` output, 1: one-cycle pulse; write the memory line into the array at `index`/`way`.
- `update` output, 1: one-cycle pulse; write the L1 line into the array at `index`/`way`.
- `way` output, 1: array way selected for the current access.
- `read_L2_MEM` output, 1: memory line-read request.
- `write_L2_MEM` output, 1: memory line-write request.
- `mem_tag` output, `TAG_W`: memory address tag. It is the victim/entry tag during write-back and the request tag during reads.
- `mem_index` output, `INDEX_W`: memory address set.
- `ready_MEM` input, 1: memory completion, sampled while `read_L2_MEM` or `write_L2_MEM` is high.
- `flush_done` output, 1: one-cycle pulse at the end of the flush sweep.

## Operation
- Per-set, per-way state: `valid`, `dirty`, and a `TAG_W` tag. Each set also has one `lru` bit naming the next victim.
- Any access (hit, install, refill) to way w sets `lru` = ~w.
- Reset (async): state IDLE; all `valid`, `dirty` and `lru` bits cleared; every output 0.
- Reset mid-transaction aborts the transaction with no completion pulse.
- Priority in IDLE: `flush` > `read_L1_L2` > `write_L1_L2`. The request type plus `tag`/`index` are latched on entry to COMPARE.

State machine:
- **IDLE**
  - `flush` → FLUSH with the counter at 0.
  - Any request → COMPARE.
- **COMPARE** (hit = `valid` & tag match in either way):
  - Read hit: `ready`=1, `way`=hit way → IDLE.
  - Write hit: `ready`=1, `update`=1, set `dirty` → IDLE.
  - Miss, victim choice: first invalid way (way 0 preferred), otherwise the `lru` way.
  - Victim valid & dirty → WRITE_BACK.
  - Clean/invalid victim, read → ALLOCATE.
  - Clean/invalid victim, write → install the tag, `valid`=1, `dirty`=1, `update`=1, `ready`=1 → IDLE. No memory fetch: the line is fully written.
- **WRITE_BACK**
  - `write_L2_MEM`=1, `mem_tag`=victim tag, `mem_index`=`index`, `way`=victim.
  - On `ready_MEM`: clear the victim's `dirty` → COMPARE, which then takes the clean-victim path.
- **ALLOCATE**
  - `read_L2_MEM`=1, `mem_tag`=`tag`.
  - On `ready_MEM` → REFILL.
- **REFILL**
  - `refill`=1, install the tag, `valid`=1, `dirty`=0 → COMPARE, which then hits.
- **FLUSH**
  - The counter covers `INDEX_W`+1 bits; its LSB is the way, the upper bits are the set.
  - Entry valid & dirty: `write_L2_MEM`=1 with the entry's tag/set; hold until `ready_MEM`.
  - After the entry is handled: clear its `valid`/`dirty`, increment the counter.
  - After the last entry → DONE.
- **DONE**
  - `flush_done`=1 → IDLE.
  - `lru` is cleared.
- Requests arriving during FLUSH/DONE are not sampled; L1 keeps them asserted.

## Timing
- All outputs are Moore, decoded from state and registered arrays; no combinational path from `ready_MEM` to any output.
- The cycle IDLE samples a request is cycle 0.
  - Hit: `ready` in cycle 1.
  - Clean write miss: `ready` in cycle 1.
  - Clean read miss, memory latency L ≥ 1 ALLOCATE cycles: REFILL at cycle 1+L+1, `ready` one cycle later.
  - Dirty victim: adds the WRITE_BACK cycles before the same path.
- Memory request lines stay high continuously until `ready_MEM` is sampled. They are low the next cycle.
- L1 deasserts its request the cycle after `ready`. A request still high in the IDLE cycle after `ready` is treated as a new transaction.
- Clean flush with no dirty lines: 2^(`INDEX_W`+1) FLUSH cycles, then `flush_done`.

## Test plan
- **Reset.** Assert `nrst`=0 mid-ALLOCATE → all outputs 0 immediately. Then read `tag`=0x5, `index`=3 → miss (all valid bits cleared), `read_L2_MEM` asserted.
- **Read miss then hit.** Read `tag`=0x5, `index`=3 with `ready_MEM` one cycle later → `refill` at cycle 3, `ready` at cycle 4, `way`=0. Repeat the same read → `ready` at cycle 1, no memory traffic.
- **Write allocate.** Write `tag`=0x9, `index`=3 → `ready`+`update` at cycle 1, `way`=1. Read `tag`=0x5 → hit in way 0.
- **Dirty eviction.** Set 3 is full, `lru`=1, way 1 dirty with tag 0x9. Read `tag`=0x7, `index`=3 → `write_L2_MEM` with `mem_tag`=0x9, then `read_L2_MEM` with `mem_tag`=0x7, `refill` on way 1, `ready`.
- **Flush.** `INDEX_W`=2, one dirty line at set 2, way 1 → exactly one `write_L2_MEM` (set 2), `flush_done` after 8 FLUSH cycles plus memory wait. All subsequent reads miss.
- **Simultaneous requests.** `flush` and `read_L1_L2` asserted in the same IDLE cycle → FLUSH runs first with `ready` held 0. The read completes after `flush_done`.
